// File: rtl/noc_flit_pkg.sv
// Shared definitions for the mesh link transmitter: flit type codes, framing
// states and the constant clog2 helper used to size counters.
package noc_flit_pkg;

   // Flit type occupies the top TYPE_W bits of every flit.
   localparam int unsigned TYPE_W = 2;

   localparam logic [TYPE_W-1:0] FLIT_BODY   = 2'b00;
   localparam logic [TYPE_W-1:0] FLIT_HEAD   = 2'b01;
   localparam logic [TYPE_W-1:0] FLIT_TAIL   = 2'b10;
   localparam logic [TYPE_W-1:0] FLIT_SINGLE = 2'b11;

   localparam logic ST_IDLE   = 1'b0;
   localparam logic ST_IN_PKT = 1'b1;

   function automatic int unsigned clog2(input int unsigned value);
      int unsigned r = 0;
      int unsigned v = 1;
      while (v < value) begin
         v = v << 1;
         r = r + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/noc_credit_counter.sv
// Downstream buffer credit counter: reserves a credit per issued read, accepts
// returned credits, saturates at CREDITS and flags any excess return.
module noc_credit_counter
   import noc_flit_pkg::*;
#(
   parameter int unsigned CREDITS = 8,
   localparam int unsigned CW = clog2(CREDITS) + 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          consume,
   input  logic          credit_in,
   output logic [CW-1:0] count,
   output logic          err
);

   logic [CW-1:0] count_d;
   logic          err_d;
   logic          full;

   assign full = (count == CW'(CREDITS));

   always_comb begin
      count_d = count;
      err_d   = err;
      // A simultaneous consume and return cancel out, even when full.
      if (consume && !credit_in) begin
         count_d = count - CW'(1);
      end else if (!consume && credit_in) begin
         if (full) begin
            err_d = 1'b1;
         end else begin
            count_d = count + CW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst_n) begin
         count <= CW'(CREDITS);
         err   <= 1'b0;
      end else begin
         count <= count_d;
         err   <= err_d;
      end
   end

endmodule

// File: rtl/flit_link_tx.sv
// Mesh link transmitter: pops flits from the input FIFO under credit flow
// control, registers them onto the link and tracks packet framing.
module flit_link_tx
   import noc_flit_pkg::*;
#(
   parameter int unsigned NUM_BITS = 16,
   parameter int unsigned CREDITS  = 8,
   localparam int unsigned CW = clog2(CREDITS) + 1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                fifo_empty,
   input  logic [NUM_BITS-1:0] fifo_out,
   output logic                rd_en,
   output logic                link_valid,
   output logic [NUM_BITS-1:0] link_flit,
   input  logic                credit_in,
   output logic [CW-1:0]       credit_count,
   output logic                pkt_active,
   output logic [15:0]         pkt_count,
   output logic                err_proto,
   output logic                err_credit
);

   logic              rd_pending;
   logic              state;
   logic              state_d;
   logic [15:0]       pkt_count_d;
   logic              err_proto_d;
   logic [TYPE_W-1:0] ftype;

   // The credit is reserved at issue, so the popped flit always has room.
   assign rd_en = !rst_n && !fifo_empty && (credit_count != '0);

   assign ftype      = fifo_out[NUM_BITS-1 -: TYPE_W];
   assign pkt_active = (state == ST_IN_PKT);

   noc_credit_counter #(
      .CREDITS (CREDITS)
   ) u_credit (
      .clk       (clk),
      .rst_n     (rst_n),
      .consume   (rd_en),
      .credit_in (credit_in),
      .count     (credit_count),
      .err       (err_credit)
   );

   always_comb begin
      state_d     = state;
      pkt_count_d = pkt_count;
      err_proto_d = err_proto;
      if (rd_pending) begin
         if (state == ST_IDLE) begin
            unique case (ftype)
               FLIT_HEAD:   state_d = ST_IN_PKT;
               FLIT_SINGLE: pkt_count_d = pkt_count + 16'd1;
               FLIT_BODY,
               FLIT_TAIL:   err_proto_d = 1'b1;
               default:     state_d = state;
            endcase
         end else begin
            // A stray start inside a packet is reported and treated as a new packet.
            unique case (ftype)
               FLIT_BODY:   state_d = ST_IN_PKT;
               FLIT_TAIL: begin
                  state_d     = ST_IDLE;
                  pkt_count_d = pkt_count + 16'd1;
               end
               FLIT_HEAD,
               FLIT_SINGLE: err_proto_d = 1'b1;
               default:     state_d = state;
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst_n) begin
         rd_pending <= 1'b0;
         link_valid <= 1'b0;
         link_flit  <= '0;
         state      <= ST_IDLE;
         pkt_count  <= 16'd0;
         err_proto  <= 1'b0;
      end else begin
         rd_pending <= rd_en;
         link_valid <= rd_pending;
         if (rd_pending) begin
            link_flit <= fifo_out;
         end
         state     <= state_d;
         pkt_count <= pkt_count_d;
         err_proto <= err_proto_d;
      end
   end

endmodule

// File: tb/tb_flit_link_tx.sv
// Bench for flit_link_tx: queue-based FIFO and scoreboard model, a directed
// vector table, hand-written corner sequences and a randomized run.
module tb_flit_link_tx;

   localparam int unsigned NB = 16;
   localparam int unsigned CR = 8;
   localparam int unsigned CW = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic          fifo_empty = 1'b1;
   logic [NB-1:0] fifo_out = '0;
   logic          rd_en;
   logic          link_valid;
   logic [NB-1:0] link_flit;
   logic          credit_in = 1'b0;
   logic [CW-1:0] credit_count;
   logic          pkt_active;
   logic [15:0]   pkt_count;
   logic          err_proto;
   logic          err_credit;

   always #5 clk = ~clk;

   flit_link_tx #(
      .NUM_BITS (NB),
      .CREDITS  (CR)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .fifo_empty   (fifo_empty),
      .fifo_out     (fifo_out),
      .rd_en        (rd_en),
      .link_valid   (link_valid),
      .link_flit    (link_flit),
      .credit_in    (credit_in),
      .credit_count (credit_count),
      .pkt_active   (pkt_active),
      .pkt_count    (pkt_count),
      .err_proto    (err_proto),
      .err_credit   (err_credit)
   );

   typedef struct {
      int          t;
      logic [15:0] f;
   } ev_t;

   typedef struct {
      bit          rd;
      bit          lv;
      logic [15:0] lf;
      int          cr;
      bit          act;
      int          pk;
   } vec_t;

   int          n_cmp = 0;
   int          n_bad = 0;
   int          cyc = 0;
   int          sent = 0;
   logic [15:0] q[$];
   ev_t         evq[$];
   int          m_cred = CR;
   bit          m_errc = 0;
   bit          m_errp = 0;
   bit          m_act = 0;
   logic [15:0] m_pkts = 0;
   logic [15:0] m_lf = 0;
   bit          exp_lv = 0;
   logic        rd_seen = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Packet framing rules applied to each flit as it appears on the link.
   function automatic void frame(input logic [15:0] f);
      case (f[15:14])
         2'b01: if (m_act) m_errp = 1; else m_act = 1;
         2'b11: if (m_act) m_errp = 1; else m_pkts = m_pkts + 16'd1;
         2'b00: if (!m_act) m_errp = 1;
         default: begin
            if (m_act) begin
               m_act  = 0;
               m_pkts = m_pkts + 16'd1;
            end else begin
               m_errp = 1;
            end
         end
      endcase
   endfunction

   task automatic push(input logic [15:0] f);
      q.push_back(f);
      fifo_empty = 1'b0;
   endtask

   task automatic tick(input bit rst, input bit cin);
      bit          er;
      logic [15:0] f;
      ev_t         e;
      rst_n     = rst;
      credit_in = cin;
      #1;
      er = !rst && (q.size() != 0) && (m_cred != 0);
      chk("rd_en", {31'd0, rd_en}, {31'd0, er});
      rd_seen = rd_en;
      @(posedge clk);
      #1;
      cyc++;
      exp_lv = 0;
      if (rst) begin
         m_cred = CR; m_errc = 0; m_errp = 0; m_act = 0; m_pkts = 0; m_lf = 0;
         q.delete();
         evq.delete();
      end else begin
         if (er && !cin) m_cred--;
         else if (!er && cin) begin
            if (m_cred == CR) m_errc = 1;
            else m_cred++;
         end
         if (evq.size() != 0 && evq[0].t == cyc) begin
            e      = evq.pop_front();
            exp_lv = 1;
            m_lf   = e.f;
            sent++;
            frame(e.f);
         end
         if (er) begin
            f        = q.pop_front();
            fifo_out = f;
            evq.push_back('{cyc + 1, f});
         end
      end
      fifo_empty = (q.size() == 0);
      chk("link_valid", {31'd0, link_valid}, {31'd0, exp_lv});
      chk("link_flit", {16'd0, link_flit}, {16'd0, m_lf});
      chk("credit_count", {28'd0, credit_count}, m_cred);
      chk("pkt_active", {31'd0, pkt_active}, {31'd0, m_act});
      chk("pkt_count", {16'd0, pkt_count}, {16'd0, m_pkts});
      chk("err_proto", {31'd0, err_proto}, {31'd0, m_errp});
      chk("err_credit", {31'd0, err_credit}, {31'd0, m_errc});
   endtask

   vec_t tbl[5];

   initial begin
      tbl[0] = '{rd: 1, lv: 0, lf: 16'h0000, cr: 7, act: 0, pk: 0};
      tbl[1] = '{rd: 1, lv: 1, lf: 16'h4001, cr: 6, act: 1, pk: 0};
      tbl[2] = '{rd: 1, lv: 1, lf: 16'h0002, cr: 5, act: 1, pk: 0};
      tbl[3] = '{rd: 0, lv: 1, lf: 16'h8003, cr: 5, act: 0, pk: 1};
      tbl[4] = '{rd: 0, lv: 0, lf: 16'h8003, cr: 5, act: 0, pk: 1};

      tick(1, 0);
      tick(1, 0);

      // Three-flit packet against hand-computed vectors.
      push(16'h4001); push(16'h0002); push(16'h8003);
      for (int i = 0; i < 5; i++) begin
         tick(0, 0);
         chk("tbl_rd", {31'd0, rd_seen}, {31'd0, tbl[i].rd});
         chk("tbl_lv", {31'd0, link_valid}, {31'd0, tbl[i].lv});
         chk("tbl_lf", {16'd0, link_flit}, {16'd0, tbl[i].lf});
         chk("tbl_cr", {28'd0, credit_count}, tbl[i].cr);
         chk("tbl_act", {31'd0, pkt_active}, {31'd0, tbl[i].act});
         chk("tbl_pk", {16'd0, pkt_count}, tbl[i].pk);
      end

      // Credit exhaustion, then a single returned credit.
      tick(1, 0);
      for (int i = 0; i < 10; i++) push(16'hC000 + 16'(i));
      sent = 0;
      repeat (14) tick(0, 0);
      chk("exhaust_sent", sent, 8);
      chk("exhaust_cred", {28'd0, credit_count}, 0);
      chk("exhaust_rd_low", {31'd0, rd_seen}, 0);
      tick(0, 1);
      tick(0, 0);
      chk("credit_rd", {31'd0, rd_seen}, 1);
      tick(0, 0);
      tick(0, 0);
      chk("credit_one_more", sent, 9);
      repeat (3) tick(0, 0);
      chk("credit_no_more", sent, 9);

      // Continuous stream with a credit returned every cycle.
      tick(1, 0);
      for (int i = 0; i < 20; i++) push(16'hC100 + 16'(i));
      for (int i = 0; i < 22; i++) begin
         tick(0, i <= 19);
         if (i >= 1 && i <= 20) begin
            chk("stream_lv", {31'd0, link_valid}, 1);
            chk("stream_cred", {28'd0, credit_count}, CR);
         end
      end

      // Framing errors: stray BODY, then a HEAD inside a packet.
      tick(1, 0);
      push(16'h0005);
      tick(0, 0);
      tick(0, 0);
      chk("stray_body_err", {31'd0, err_proto}, 1);
      chk("stray_body_fwd", {16'd0, link_flit}, 16'h0005);
      chk("stray_body_pk", {16'd0, pkt_count}, 0);
      push(16'h4006); push(16'h4007);
      repeat (4) tick(0, 0);
      chk("dbl_head_err", {31'd0, err_proto}, 1);
      chk("dbl_head_act", {31'd0, pkt_active}, 1);
      chk("dbl_head_flit", {16'd0, link_flit}, 16'h4007);

      // Credit return while already full.
      tick(1, 0);
      tick(0, 1);
      chk("ovf_err", {31'd0, err_credit}, 1);
      chk("ovf_cred", {28'd0, credit_count}, CR);
      tick(0, 0);
      chk("ovf_sticky", {31'd0, err_credit}, 1);

      // Reset in the cycle after a read is issued.
      tick(1, 0);
      push(16'hC201); push(16'hC202);
      sent = 0;
      tick(0, 0);
      chk("rstmid_rd", {31'd0, rd_seen}, 1);
      tick(1, 0);
      chk("rstmid_lv", {31'd0, link_valid}, 0);
      chk("rstmid_cred", {28'd0, credit_count}, CR);
      repeat (3) tick(0, 0);
      chk("rstmid_dropped", sent, 0);

      // Randomized traffic against the model.
      tick(1, 0);
      for (int i = 0; i < 600; i++) begin
         logic [1:0] ty;
         if ($urandom_range(1, 0) == 1) begin
            ty = 2'($urandom_range(3, 0));
            push({ty, 14'($urandom)});
         end
         tick($urandom_range(99, 0) == 0, $urandom_range(2, 0) == 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/flit_link_tx.md
# flit_link_tx

Link transmitter that drains a router input FIFO (16-bit flits, 1-cycle registered read latency) and drives flits onto the inter-router mesh link under credit-based flow control. It issues read enables only when the FIFO is non-empty and a downstream buffer credit is held, forwards each popped flit as a registered valid/flit pair, and tracks packet framing from the flit type field. It sits between each port's input FIFO and the outgoing link toward the neighbouring router's input FIFO.

## Interface
- NUM_BITS, 16, flit width; bits [NUM_BITS-1:NUM_BITS-2] hold the flit type.
- CREDITS, 8, downstream FIFO depth, which is also the initial credit count.
- CW, clog2(CREDITS)+1, credit counter width (derived; not overridden).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  synchronous, active-high reset (the name is kept for consistency).
- fifo_empty  in  1  upstream FIFO empty flag.
- fifo_out  in  NUM_BITS  upstream FIFO data; valid the cycle after rd_en.
- rd_en  out  1  pop request to the upstream FIFO.
- link_valid  out  1  link flit valid; one flit per high cycle.
- link_flit  out  NUM_BITS  link flit data.
- credit_in  in  1  one credit returned per high cycle.
- credit_count  out  CW  credits currently held.
- pkt_active  out  1  a head has been sent and its tail has not.
- pkt_count  out  16  number of completed packets; wraps.
- err_proto  out  1  sticky framing error.
- err_credit  out  1  sticky credit overflow.

## Operation
- Flit type encodings: 2'b01 HEAD, 2'b00 BODY, 2'b10 TAIL, 2'b11 SINGLE.
- rd_en = !rst_n && !fifo_empty && (credit_count != 0). This is combinational. Credits are reserved at issue.
- credit_count next value:
  - rd_en and credit_in together: unchanged.
  - rd_en only: decrement by 1.
  - credit_in only: increment by 1, saturating at CREDITS. A credit_in while credit_count == CREDITS sets err_credit and leaves the count unchanged.
- rd_pending register: loaded with rd_en every cycle.
- Capture: when rd_pending = 1, link_flit <= fifo_out and link_valid <= 1. When rd_pending = 0, link_valid <= 0 and link_flit holds its value.
- Framing FSM has two states, IDLE and IN_PKT, and is evaluated on each captured flit. Every flit is forwarded regardless of framing errors.
  - IDLE + HEAD: go to IN_PKT.
  - IDLE + SINGLE: stay in IDLE; pkt_count increments.
  - IDLE + BODY or TAIL: set err_proto; stay in IDLE.
  - IN_PKT + BODY: stay in IN_PKT.
  - IN_PKT + TAIL: go to IDLE; pkt_count increments.
  - IN_PKT + HEAD or SINGLE: set err_proto; stay in IN_PKT (treated as a new packet start).
- pkt_active = (state == IN_PKT), registered. It updates in the same cycle link_valid goes high.
- Reset values: credit_count = CREDITS, rd_pending = 0, link_valid = 0, link_flit = 0, state = IDLE, pkt_count = 0, err_proto = 0, err_credit = 0.
- A sticky error clears only on reset.

## Timing
- Latency: rd_en high in cycle t → FIFO data present in t+1 → link_valid and link_flit present in t+2.
- Throughput: one flit per cycle while credits are held and the FIFO is non-empty.
- Credit loop: a credit_in in cycle t is usable for rd_en in cycle t+1.
- With zero credits, rd_en stays low even if the FIFO is non-empty.
- When the FIFO becomes empty, rd_en drops in the same cycle. A flit already read continues to completion.
- Reset mid-operation: an in-flight flit (rd_pending set) is dropped, and link_valid is 0 in the cycle after reset. The upstream FIFO shares this reset.
- rd_en is never high while rst_n is high.

## Structure
- Package noc_flit_pkg holds:
  - the flit type localparams (HEAD/BODY/TAIL/SINGLE) and the type-field position;
  - the clog2 function;
  - the FSM state encoding (IDLE = 1'b0, IN_PKT = 1'b1).
- One sub-module, noc_credit_counter, contains the credit counter, its saturation logic and err_credit. Parameter: CREDITS. Ports: clk, rst_n, consume, credit_in, count, err.

## Test plan
- Reset, then push 3 flits (0x4001, 0x0002, 0x8003) with CREDITS=8 → link_valid for 3 consecutive cycles starting 2 cycles after the first rd_en; credit_count = 5; pkt_count = 1; pkt_active high for 2 cycles.
- Push 10 flits with no credit_in → exactly 8 flits sent; rd_en stays low with credit_count = 0. One credit_in pulse → exactly one more flit is sent 2 cycles later.
- Continuous stream with credit_in pulsed every cycle → credit_count stays constant and link_valid stays high every cycle.
- Send BODY 0x0005 in IDLE → err_proto = 1; flit still forwarded; pkt_count unchanged. Send HEAD 0x4006 then HEAD 0x4007 → err_proto stays set and pkt_active stays high.
- Raise credit_in while credit_count = 8 → err_credit = 1 and credit_count stays 8.
- Assert rst_n in the cycle after rd_en → no link_valid follows; all outputs return to their reset values on the next cycle.
